// File: rtl/host_bus_pkg.sv
// host_bus_pkg: shared types and constants for the 8080-style host bus
// initiator (host_bus_master).
//   state_t      - bus-cycle FSM states
//   CNT_W        - width of the shared phase down-counter
//   DEF_T_*      - default phase lengths in clock cycles
//   cnt_load()   - counter value loaded on entry to a phase of length t
package host_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RECOV  = 3'd4
  } state_t;

  localparam int CNT_W = 4;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 4;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_RECOV = 2;

  // A phase of t cycles starts at t-1 and ends when the counter reads 0.
  // A zero-length phase is never entered, so it simply loads 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int t);
    return (t > 0) ? CNT_W'(t - 1) : '0;
  endfunction

endpackage

// File: rtl/host_bus_master.sv
// host_bus_master: initiator for an 8-bit 8080-style host bus (CE#, A0, WR#,
// RD#, D[7:0]). Takes one command at a time and runs a complete write or read
// bus cycle with programmable setup / strobe / hold / recovery lengths.
//
// Command handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE; cmd_valid outside IDLE
// is ignored (nothing is queued). Read data comes back as a one-cycle
// rsp_valid pulse; rsp_rdat holds the value until the next read capture.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_rnw, cmd_a0       1 = read / 0 = write, A0 value for the cycle
//   cmd_wdat              write data
//   rsp_valid, rsp_rdat   read response pulse and captured data
//   ce_x, a0, wr_x, rd_x  bus control (active-low strobes and enable)
//   dat_o, dat_oe, dat_i  data pad out / output enable / in
//   busy                  1 whenever the FSM is not in IDLE
//
// Every output is a flop whose next value is decoded from the next state, so
// pins change exactly on the edge that enters a phase.
module host_bus_master
  import host_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_RECOV = DEF_T_RECOV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdat,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdat,
  output logic       ce_x,
  output logic       a0,
  output logic       wr_x,
  output logic       rd_x,
  output logic [7:0] dat_o,
  output logic       dat_oe,
  input  logic [7:0] dat_i,
  output logic       busy
);

  if (T_SETUP < 1 || T_SETUP > 15) begin : g_chk_setup
    $error("host_bus_master: T_SETUP must be in 1..15");
  end
  if (T_PULSE < 1 || T_PULSE > 15) begin : g_chk_pulse
    $error("host_bus_master: T_PULSE must be in 1..15");
  end
  if (T_HOLD < 1 || T_HOLD > 15) begin : g_chk_hold
    $error("host_bus_master: T_HOLD must be in 1..15");
  end
  if (T_RECOV < 0 || T_RECOV > 15) begin : g_chk_recov
    $error("host_bus_master: T_RECOV must be in 0..15");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               lat_rnw, lat_rnw_nxt;
  logic               lat_a0, lat_a0_nxt;
  logic [7:0]         lat_wdat, lat_wdat_nxt;
  logic               expired;
  logic               capture;

  logic               ready_nxt, busy_nxt, ce_x_nxt, a0_nxt;
  logic               wr_x_nxt, rd_x_nxt, dat_oe_nxt, rsp_valid_nxt;
  logic [7:0]         dat_o_nxt, rsp_rdat_nxt;
  logic               active;

  assign expired = (cnt == '0);
  // Read data is sampled on the edge that leaves STROBE, i.e. at the very
  // end of the strobe where the device guarantees dat_i is stable.
  assign capture = (state == STROBE) && expired && lat_rnw;

  // State, phase counter and latched command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rnw  <= 1'b0;
      lat_a0   <= 1'b0;
      lat_wdat <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_rnw  <= lat_rnw_nxt;
      lat_a0   <= lat_a0_nxt;
      lat_wdat <= lat_wdat_nxt;
    end
  end

  // Next state, counter reload and command latch.
  always_comb begin
    state_nxt    = state;
    lat_rnw_nxt  = lat_rnw;
    lat_a0_nxt   = lat_a0;
    lat_wdat_nxt = lat_wdat;
    cnt_nxt      = cnt;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt    = SETUP;
          lat_rnw_nxt  = cmd_rnw;
          lat_a0_nxt   = cmd_a0;
          lat_wdat_nxt = cmd_wdat;
        end
      end
      SETUP:   if (expired) state_nxt = STROBE;
      STROBE:  if (expired) state_nxt = HOLD;
      HOLD:    if (expired) state_nxt = (T_RECOV > 0) ? RECOV : IDLE;
      RECOV:   if (expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // One shared counter: reload on every phase entry, otherwise count down.
    if (state_nxt != state) begin
      case (state_nxt)
        SETUP:   cnt_nxt = cnt_load(T_SETUP);
        STROBE:  cnt_nxt = cnt_load(T_PULSE);
        HOLD:    cnt_nxt = cnt_load(T_HOLD);
        RECOV:   cnt_nxt = cnt_load(T_RECOV);
        default: cnt_nxt = '0;
      endcase
    end else if (!expired) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  // Next values of the output flops, decoded from the next state and the
  // command that will be latched on the same edge.
  always_comb begin
    active        = (state_nxt == SETUP) || (state_nxt == STROBE) ||
                    (state_nxt == HOLD);
    ready_nxt     = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    ce_x_nxt      = !active;
    // a0 keeps its last driven value through RECOV and IDLE.
    a0_nxt        = (state_nxt == SETUP) ? lat_a0_nxt : a0;
    wr_x_nxt      = !((state_nxt == STROBE) && !lat_rnw_nxt);
    rd_x_nxt      = !((state_nxt == STROBE) && lat_rnw_nxt);
    dat_oe_nxt    = active && !lat_rnw_nxt;
    dat_o_nxt     = (active && !lat_rnw_nxt) ? lat_wdat_nxt : dat_o;
    rsp_valid_nxt = capture;
    rsp_rdat_nxt  = capture ? dat_i : rsp_rdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      ce_x      <= 1'b1;
      a0        <= 1'b0;
      wr_x      <= 1'b1;
      rd_x      <= 1'b1;
      dat_o     <= '0;
      dat_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdat  <= '0;
    end else begin
      cmd_ready <= ready_nxt;
      busy      <= busy_nxt;
      ce_x      <= ce_x_nxt;
      a0        <= a0_nxt;
      wr_x      <= wr_x_nxt;
      rd_x      <= rd_x_nxt;
      dat_o     <= dat_o_nxt;
      dat_oe    <= dat_oe_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdat  <= rsp_rdat_nxt;
    end
  end

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: bench for host_bus_master. Two instances share the
// input stimulus: u_dut with default timing and u_fast with 1/1/1/0 timing.
// sel chooses which instance's outputs are observed and checked.
module tb_host_bus_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_rnw   = 1'b0;
  logic       cmd_a0    = 1'b0;
  logic [7:0] cmd_wdat  = '0;
  logic [7:0] dat_i     = '0;

  logic       d_cmd_ready, d_rsp_valid, d_ce_x, d_a0, d_wr_x, d_rd_x, d_dat_oe, d_busy;
  logic [7:0] d_rsp_rdat, d_dat_o;
  logic       f_cmd_ready, f_rsp_valid, f_ce_x, f_a0, f_wr_x, f_rd_x, f_dat_oe, f_busy;
  logic [7:0] f_rsp_rdat, f_dat_o;

  host_bus_master u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(d_cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_a0(cmd_a0), .cmd_wdat(cmd_wdat),
    .rsp_valid(d_rsp_valid), .rsp_rdat(d_rsp_rdat),
    .ce_x(d_ce_x), .a0(d_a0), .wr_x(d_wr_x), .rd_x(d_rd_x),
    .dat_o(d_dat_o), .dat_oe(d_dat_oe), .dat_i(dat_i), .busy(d_busy)
  );

  host_bus_master #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_RECOV(0)) u_fast (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_a0(cmd_a0), .cmd_wdat(cmd_wdat),
    .rsp_valid(f_rsp_valid), .rsp_rdat(f_rsp_rdat),
    .ce_x(f_ce_x), .a0(f_a0), .wr_x(f_wr_x), .rd_x(f_rd_x),
    .dat_o(f_dat_o), .dat_oe(f_dat_oe), .dat_i(dat_i), .busy(f_busy)
  );

  bit sel = 1'b0;
  int ts = 2, tp = 4, th = 2, tr = 2;

  logic       o_cmd_ready, o_rsp_valid, o_ce_x, o_a0, o_wr_x, o_rd_x, o_dat_oe, o_busy;
  logic [7:0] o_rsp_rdat, o_dat_o;
  assign o_cmd_ready = sel ? f_cmd_ready : d_cmd_ready;
  assign o_rsp_valid = sel ? f_rsp_valid : d_rsp_valid;
  assign o_rsp_rdat  = sel ? f_rsp_rdat  : d_rsp_rdat;
  assign o_ce_x      = sel ? f_ce_x      : d_ce_x;
  assign o_a0        = sel ? f_a0        : d_a0;
  assign o_wr_x      = sel ? f_wr_x      : d_wr_x;
  assign o_rd_x      = sel ? f_rd_x      : d_rd_x;
  assign o_dat_o     = sel ? f_dat_o     : d_dat_o;
  assign o_dat_oe    = sel ? f_dat_oe    : d_dat_oe;
  assign o_busy      = sel ? f_busy      : d_busy;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && o_rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else                   chk("rsp_rdat", o_rsp_rdat, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; waits (bounded) for cmd_ready, then presents a
  // command. Reads push their expected data when push is set.
  task automatic drive_cmd(input logic rnw, input logic a0v, input logic [7:0] wd,
                           input logic [7:0] rv, input bit push);
    int n = 0;
    while (!o_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_a0    = a0v;
    cmd_wdat  = wd;
    if (rnw && push) exp_q.push_back(rv);
  endtask

  // Follows one bus cycle from the accept edge until cmd_ready returns,
  // playing the device side of dat_i, and checks the measured timing.
  // k counts negedges after the accept edge (k = 1 is the first cycle).
  task automatic observe(input logic rnw, input logic a0e, input logic [7:0] wd,
                         input logic [7:0] rv, input bit late, input bit keep);
    int k = 0;
    int ce_first = 0, ce_cnt = 0, st_first = 0, st_cnt = 0, other_cnt = 0;
    int rsp_k = 0, rsp_cnt = 0, ready_k = 0;
    bit pad_bad = 1'b0;
    logic a0_seen = 1'b0;
    logic strobe, other;
    while (ready_k == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!keep) cmd_valid = 1'b0;
        chk("busy", o_busy, 1);
        a0_seen = o_a0;
      end
      strobe = rnw ? o_rd_x : o_wr_x;
      other  = rnw ? o_wr_x : o_rd_x;
      if (!o_ce_x) begin
        ce_cnt++;
        if (ce_first == 0) ce_first = k;
      end
      if (!strobe) begin
        st_cnt++;
        if (st_first == 0) st_first = k;
      end
      if (!other) other_cnt++;
      if (o_rsp_valid) begin
        rsp_cnt++;
        rsp_k = k;
      end
      if (rnw && o_dat_oe) pad_bad = 1'b1;
      if (!rnw && !o_ce_x && (!o_dat_oe || o_dat_o !== wd)) pad_bad = 1'b1;
      if (rnw && !o_rd_x && (!late || k == ts + tp)) dat_i = rv;
      else dat_i = 8'hE7;
      if (o_cmd_ready) ready_k = k;
    end
    chk("ce_fall_k", ce_first, 1);
    chk("ce_low_len", ce_cnt, ts + tp + th);
    chk("strobe_start", st_first, ts + 1);
    chk("strobe_len", st_cnt, tp);
    chk("other_strobe", other_cnt, 0);
    chk("rsp_count", rsp_cnt, rnw);
    if (rnw) chk("rsp_k", rsp_k, ts + tp + 1);
    chk("ready_k", ready_k, ts + tp + th + tr + 1);
    chk("a0_value", a0_seen, a0e);
    chk(rnw ? "read_dat_oe" : "write_pads", pad_bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r_rnw, r_a0;
    logic [7:0] r_wd, r_rv;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_ce_x", o_ce_x, 1);
    chk("rst_wr_x", o_wr_x, 1);
    chk("rst_rd_x", o_rd_x, 1);
    chk("rst_a0", o_a0, 0);
    chk("rst_dat_o", o_dat_o, 0);
    chk("rst_dat_oe", o_dat_oe, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_rdat", o_rsp_rdat, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Default-timing write, then read.
    drive_cmd(1'b0, 1'b1, 8'h42, 8'h00, 1'b1);
    observe(1'b0, 1'b1, 8'h42, 8'h00, 1'b0, 1'b0);
    drive_cmd(1'b1, 1'b0, 8'h00, 8'hA5, 1'b1);
    observe(1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);

    // cmd_valid held high through a write; the read follows at the first
    // cmd_ready cycle, so the second CE# fall lands 11 cycles after the first.
    drive_cmd(1'b0, 1'b0, 8'h11, 8'h00, 1'b1);
    observe(1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1);
    drive_cmd(1'b1, 1'b1, 8'h00, 8'h5A, 1'b1);
    observe(1'b1, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0);

    // Read data valid only in the final strobe cycle.
    drive_cmd(1'b1, 1'b0, 8'h00, 8'h3C, 1'b1);
    observe(1'b1, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0);

    // Reset during the second STROBE cycle of a read.
    drive_cmd(1'b1, 1'b0, 8'h00, 8'h99, 1'b0);
    dat_i = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_rd_x", o_rd_x, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_x", o_rd_x, 1);
    chk("mid_rst_ce_x", o_ce_x, 1);
    chk("mid_rst_cmd_ready", o_cmd_ready, 1);
    chk("mid_rst_rsp_valid", o_rsp_valid, 0);
    chk("mid_rst_rsp_rdat", o_rsp_rdat, 0);
    chk("mid_rst_dat_oe", o_dat_oe, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_rsp_rdat", o_rsp_rdat, 0);

    // Random commands with random idle gaps.
    for (int i = 0; i < 5; i++) begin
      r_rnw = 1'($urandom_range(0, 1));
      r_a0  = 1'($urandom_range(0, 1));
      r_wd  = 8'($urandom_range(0, 255));
      r_rv  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_cmd(r_rnw, r_a0, r_wd, r_rv, 1'b1);
      observe(r_rnw, r_a0, r_wd, r_rv, 1'b0, 1'b0);
    end

    // Minimum timing, no recovery: back-to-back commands, period 4.
    repeat (12) @(negedge clk);
    sel = 1'b1;
    ts = 1; tp = 1; th = 1; tr = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b0, 1'(i), 8'(8'h10 + i), 8'h00, 1'b1);
      observe(1'b0, 1'(i), 8'(8'h10 + i), 8'h00, 1'b0, 1'b0);
    end
    drive_cmd(1'b1, 1'b1, 8'h00, 8'hC3, 1'b1);
    observe(1'b1, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
